// File: rtl/cpu_boot_seq.sv
// cpu_boot_seq: multi-hart boot/run sequencer.
//   Holds every hart in reset for RST_HOLD cycles after an accepted start and
//   then releases the harts' active-low resets in order, one every STAGGER
//   cycles (all together when STAGGER is 0). Drives a per-hart reset vector,
//   counts RUN cycles, and ends the run on halt_req or, optionally, on a
//   cycle limit.
//
// Optional feature macro:
//   CPU_BOOT_SEQ_TIMEOUT_EN : when defined, RUN also ends after TIMEOUT cycles
//                             and the timeout flag is raised. When undefined,
//                             timeout is constant 0 and TIMEOUT has no effect.
//
// Ports:
//   clk         in   1                  system clock
//   rst         in   1                  synchronous, active-high reset
//   start       in   1                  start/restart pulse (taken in IDLE/DONE)
//   rtvec_base  in   PC_SIZE            hart-0 reset vector, latched on start
//   halt_req    in   1                  end-of-run request
//   hart_rst_n  out  NUM_HARTS          per-hart active-low core reset
//   pc_rtvec    out  NUM_HARTS*PC_SIZE  hart i vector at [i*PC_SIZE +: PC_SIZE]
//   run         out  1                  high while in RUN
//   done        out  1                  sticky end-of-run flag
//   timeout     out  1                  run ended by the cycle limit
//   cycle_cnt   out  32                 saturating RUN-cycle count

module cpu_boot_seq #(
    parameter int unsigned NUM_HARTS   = 2,
    parameter int unsigned PC_SIZE     = 32,
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned STAGGER     = 3,
    parameter logic [31:0] HART_STRIDE = 32'h100,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PC_SIZE-1:0]           rtvec_base,
    input  logic                         halt_req,
    output logic [NUM_HARTS-1:0]         hart_rst_n,
    output logic [NUM_HARTS*PC_SIZE-1:0] pc_rtvec,
    output logic                         run,
    output logic                         done,
    output logic                         timeout,
    output logic [31:0]                  cycle_cnt
);

    // Timer must be able to hold RST_HOLD and STAGGER-1.
    localparam int unsigned HOLD_MAX  = (RST_HOLD > STAGGER) ? RST_HOLD : STAGGER;
    localparam int unsigned TMR_W     = $clog2(HOLD_MAX + 1);
    localparam int unsigned IDX_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int unsigned STAG_LAST = (STAGGER > 0) ? (STAGGER - 1) : 0;

    // Every hart leaves reset on the same edge when there is nothing to stagger.
    localparam bit RELEASE_ALL = (STAGGER == 0) || (NUM_HARTS == 1);

    localparam logic [TMR_W-1:0] HOLD_END  = TMR_W'(RST_HOLD);
    localparam logic [TMR_W-1:0] STAG_END  = TMR_W'(STAG_LAST);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_HARTS - 1);
    localparam logic [31:0]      CNT_MAX   = 32'hFFFF_FFFF;

`ifdef CPU_BOOT_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;     // cycles spent in current HOLD / stagger slot
    logic [IDX_W-1:0] hart_idx;  // next hart to release while in RELEASE

    logic active_c;       // a run is in progress (halt_req is honoured)
    logic timeout_hit_c;  // this RUN cycle is the last one allowed
    logic stop_c;         // run ends at this edge

    assign active_c      = (state == S_HOLD) || (state == S_RELEASE) || (state == S_RUN);
    assign timeout_hit_c = TIMEOUT_EN && (state == S_RUN) && (cycle_cnt == TIMEOUT_LAST);
    assign stop_c        = active_c && (halt_req || timeout_hit_c);

    // Sequencer state, timers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            hart_idx   <= '0;
            hart_rst_n <= '0;
            pc_rtvec   <= '0;
            run        <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            // RUN counts every edge spent in RUN, including the one that leaves it.
            if ((state == S_RUN) && (cycle_cnt != CNT_MAX)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end

            if (stop_c) begin
                // halt_req outranks both a pending release and the cycle limit.
                state      <= S_DONE;
                hart_rst_n <= '0;
                run        <= 1'b0;
                done       <= 1'b1;
                timeout    <= timeout_hit_c && !halt_req;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            // Vectors wrap modulo 2^PC_SIZE.
                            for (int i = 0; i < int'(NUM_HARTS); i++) begin
                                pc_rtvec[i*PC_SIZE +: PC_SIZE] <=
                                    rtvec_base + PC_SIZE'(64'(i) * 64'(HART_STRIDE));
                            end
                            cycle_cnt  <= '0;
                            done       <= 1'b0;
                            timeout    <= 1'b0;
                            hart_rst_n <= '0;
                            timer      <= '0;
                            hart_idx   <= '0;
                            state      <= S_HOLD;
                        end
                    end

                    S_HOLD: begin
                        // timer reaches RST_HOLD on the (RST_HOLD+1)th edge after start.
                        if (timer == HOLD_END) begin
                            timer <= '0;
                            if (RELEASE_ALL) begin
                                hart_rst_n <= '1;
                                run        <= 1'b1;
                                state      <= S_RUN;
                            end else begin
                                hart_rst_n <= NUM_HARTS'(1);
                                hart_idx   <= IDX_W'(1);
                                state      <= S_RELEASE;
                            end
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end

                    S_RELEASE: begin
                        // One hart per STAGGER cycles; RUN starts with the last one.
                        if (timer == STAG_END) begin
                            timer      <= '0;
                            hart_rst_n <= hart_rst_n | (NUM_HARTS'(1) << hart_idx);
                            if (hart_idx == LAST_IDX) begin
                                run   <= 1'b1;
                                state <= S_RUN;
                            end else begin
                                hart_idx <= hart_idx + IDX_W'(1);
                            end
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end

                    S_RUN: begin
                        // Counting handled above; leaving RUN handled by stop_c.
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_boot_seq.sv
// Directed bench for cpu_boot_seq: u_a uses stagger 3, u_b uses stagger 0
// with a 20-cycle run limit. Edge numbers count rising clock edges from 1.
module tb_cpu_boot_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [31:0] base_a  = '0;
    logic        halt_a  = 1'b0;
    logic [1:0]  hrn_a;
    logic [63:0] pc_a;
    logic        run_a, done_a, to_a;
    logic [31:0] cnt_a;

    logic        start_b = 1'b0;
    logic [31:0] base_b  = '0;
    logic        halt_b  = 1'b0;
    logic [1:0]  hrn_b;
    logic [63:0] pc_b;
    logic        run_b, done_b, to_b;
    logic [31:0] cnt_b;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    cpu_boot_seq #(
        .NUM_HARTS(2), .PC_SIZE(32), .RST_HOLD(4), .STAGGER(3),
        .HART_STRIDE(32'h100), .TIMEOUT(1000)
    ) u_a (
        .clk(clk), .rst(rst), .start(start_a), .rtvec_base(base_a),
        .halt_req(halt_a), .hart_rst_n(hrn_a), .pc_rtvec(pc_a),
        .run(run_a), .done(done_a), .timeout(to_a), .cycle_cnt(cnt_a)
    );

    cpu_boot_seq #(
        .NUM_HARTS(2), .PC_SIZE(32), .RST_HOLD(4), .STAGGER(0),
        .HART_STRIDE(32'h100), .TIMEOUT(20)
    ) u_b (
        .clk(clk), .rst(rst), .start(start_b), .rtvec_base(base_b),
        .halt_req(halt_b), .hart_rst_n(hrn_b), .pc_rtvec(pc_b),
        .run(run_b), .done(done_b), .timeout(to_b), .cycle_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after edge e.
    task automatic step_to(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
            #1;
        end
    endtask

    initial begin
        // Reset
        step_to(2);
        chk("rst_hrn",  64'(hrn_a), 64'h0);
        chk("rst_pc",   pc_a,       64'h0);
        chk("rst_run",  64'(run_a), 64'h0);
        chk("rst_done", 64'(done_a),64'h0);
        chk("rst_to",   64'(to_a),  64'h0);
        chk("rst_cnt",  64'(cnt_a), 64'h0);
        rst = 1'b0;

        // Start both at edge 10
        step_to(9);
        start_a = 1'b1; base_a = 32'h4;
        start_b = 1'b1; base_b = 32'h8000_0000;
        step_to(10);
        start_a = 1'b0; start_b = 1'b0;
        chk("a10_hrn", 64'(hrn_a), 64'h0);
        chk("a10_pc",  pc_a,       {32'h104, 32'h4});
        chk("b10_pc",  pc_b,       {32'h8000_0100, 32'h8000_0000});

        step_to(14);
        chk("a14_hrn", 64'(hrn_a), 64'h0);
        chk("b14_hrn", 64'(hrn_b), 64'h0);
        chk("b14_run", 64'(run_b), 64'h0);

        step_to(15);
        chk("a15_hrn", 64'(hrn_a), 64'h1);
        chk("a15_run", 64'(run_a), 64'h0);
        chk("b15_hrn", 64'(hrn_b), 64'h3);
        chk("b15_run", 64'(run_b), 64'h1);
        chk("b15_cnt", 64'(cnt_b), 64'h0);

        step_to(17);
        chk("a17_hrn", 64'(hrn_a), 64'h1);
        chk("a17_run", 64'(run_a), 64'h0);

        step_to(18);
        chk("a18_hrn", 64'(hrn_a), 64'h3);
        chk("a18_run", 64'(run_a), 64'h1);
        chk("a18_cnt", 64'(cnt_a), 64'h0);

        // Halt: sampled at edge 31
        step_to(30);
        chk("a30_cnt", 64'(cnt_a), 64'd12);
        halt_a = 1'b1;
        step_to(31);
        halt_a = 1'b0;
        chk("a31_done", 64'(done_a), 64'h1);
        chk("a31_hrn",  64'(hrn_a),  64'h0);
        chk("a31_run",  64'(run_a),  64'h0);
        chk("a31_cnt",  64'(cnt_a),  64'd13);
        chk("a31_to",   64'(to_a),   64'h0);

        // u_b run limit
        step_to(34);
        chk("b34_cnt",  64'(cnt_b),  64'd19);
        chk("b34_run",  64'(run_b),  64'h1);
        step_to(35);
`ifdef CPU_BOOT_SEQ_TIMEOUT_EN
        chk("b35_done", 64'(done_b), 64'h1);
        chk("b35_to",   64'(to_b),   64'h1);
        chk("b35_run",  64'(run_b),  64'h0);
        chk("b35_hrn",  64'(hrn_b),  64'h0);
`else
        chk("b35_done", 64'(done_b), 64'h0);
        chk("b35_to",   64'(to_b),   64'h0);
        chk("b35_run",  64'(run_b),  64'h1);
`endif
        chk("b35_cnt",  64'(cnt_b),  64'd20);

        // halt ignored in DONE; values held
        halt_a = 1'b1;
        step_to(36);
        halt_a = 1'b0;
        chk("a36_done", 64'(done_a), 64'h1);
        chk("a36_cnt",  64'(cnt_a),  64'd13);
        chk("a36_pc",   pc_a,        {32'h104, 32'h4});

        // Restart from DONE at edge 40 with wrapping base
        step_to(39);
        start_a = 1'b1; base_a = 32'hFFFF_FFFF;
        step_to(40);
        start_a = 1'b0;
        chk("a40_done", 64'(done_a), 64'h0);
        chk("a40_cnt",  64'(cnt_a),  64'h0);
        chk("a40_pc",   pc_a,        {32'h0000_00FF, 32'hFFFF_FFFF});
        step_to(45);
        chk("a45_hrn",  64'(hrn_a),  64'h1);
        step_to(48);
        chk("a48_hrn",  64'(hrn_a),  64'h3);
        chk("a48_run",  64'(run_a),  64'h1);
        step_to(52);
        chk("a52_cnt",  64'(cnt_a),  64'd4);

        // One-cycle reset in RUN, sampled at edge 53
        rst = 1'b1;
        step_to(53);
        rst = 1'b0;
        chk("r53_hrn",  64'(hrn_a),  64'h0);
        chk("r53_pc",   pc_a,        64'h0);
        chk("r53_run",  64'(run_a),  64'h0);
        chk("r53_done", 64'(done_a), 64'h0);
        chk("r53_cnt",  64'(cnt_a),  64'h0);
        chk("r53b_run", 64'(run_b),  64'h0);
        chk("r53b_cnt", 64'(cnt_b),  64'h0);
        chk("r53b_pc",  pc_b,        64'h0);

        // Start accepted after reset; halt coincides with last release
        step_to(54);
        start_a = 1'b1; base_a = 32'h1000;
        step_to(55);
        start_a = 1'b0;
        chk("a55_pc",   pc_a,        {32'h1100, 32'h1000});
        step_to(60);
        chk("a60_hrn",  64'(hrn_a),  64'h1);
        step_to(62);
        halt_a = 1'b1;
        step_to(63);
        halt_a = 1'b0;
        chk("a63_run",  64'(run_a),  64'h0);
        chk("a63_done", 64'(done_a), 64'h1);
        chk("a63_hrn",  64'(hrn_a),  64'h0);
        chk("a63_cnt",  64'(cnt_a),  64'h0);
        step_to(65);
        chk("a65_run",  64'(run_a),  64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
